// File: rtl/key_debounce.sv
// key_debounce: synchronises a raw, bouncing input and qualifies each level
// change with a stable-cycle counter before it reaches key_out.
`timescale 1ns/1ps

module key_debounce #(
  parameter int unsigned CNT_MAX     = 1_000_000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_out,
  output logic busy
);

  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  localparam state_t S_RESET = RST_VAL ? S_HIGH : S_LOW;

  logic [SYNC_STAGES-1:0] sync;
  logic                   key_s;
  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic                   key_out_nx;

  assign key_s = sync[SYNC_STAGES-1];

  // Synchroniser shift register; only the last stage is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_in};
    end
  end

  // State, qualification counter and debounced output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RESET;
      cnt     <= '0;
      key_out <= RST_VAL;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      key_out <= key_out_nx;
    end
  end

  // Next-state logic: a candidate level must survive CNT_MAX consecutive
  // samples in a wait state; any opposite sample aborts, even on the expiry cycle.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    key_out_nx = key_out;
    unique case (state)
      S_LOW: begin
        if (key_s) begin
          state_nx = S_RISE;
          cnt_nx   = '0;
        end
      end
      S_RISE: begin
        if (!key_s) begin
          state_nx = S_LOW;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx   = S_HIGH;
          cnt_nx     = '0;
          key_out_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_HIGH: begin
        if (!key_s) begin
          state_nx = S_FALL;
          cnt_nx   = '0;
        end
      end
      S_FALL: begin
        if (key_s) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx   = S_LOW;
          cnt_nx     = '0;
          key_out_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = S_RESET;
        cnt_nx   = '0;
      end
    endcase
  end

  // Busy is a direct decode of the registered state.
  always_comb begin
    busy = (state == S_RISE) || (state == S_FALL);
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed testbench for key_debounce with CNT_MAX=4, SYNC_STAGES=2, RST_VAL=0.
// Edge numbering: inputs are set between edges; "edge e" is the e-th rising
// clock edge after the change, and outputs are sampled 1 ns after it.
`timescale 1ns/1ps

module tb_key_debounce;

  logic clk = 1'b0;
  logic rst;
  logic key_in;
  logic key_out;
  logic busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  key_debounce #(
    .CNT_MAX    (4),
    .SYNC_STAGES(2),
    .RST_VAL    (1'b0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .key_out(key_out),
    .busy   (busy)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic lvl, input int n);
    key_in = lvl;
    for (int i = 0; i < n; i++) tick();
  endtask

  // 1. Reset held with key_in=1; key_out rises at edge 7 after release.
  task automatic test_reset();
    rst = 1'b1;
    key_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (key_out !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d key_out=%b busy=%b expected 0 0", i, key_out, busy);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (key_out !== (e >= 7) || busy !== (e >= 3 && e <= 6)) begin
        miscompares++;
        $display("FAIL reset_release edge=%0d key_out=%b busy=%b expected %b %b",
                 e, key_out, busy, (e >= 7), (e >= 3 && e <= 6));
      end
    end
  endtask

  // 2. Clean press: busy over qualification, single rising edge at edge 7.
  task automatic test_clean_press();
    logic prev;
    int rises;
    idle(1'b0, 12);
    vectors++;
    if (key_out !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL press_idle key_out=%b busy=%b expected 0 0", key_out, busy);
    end
    key_in = 1'b1;
    prev = key_out;
    rises = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      vectors++;
      if (key_out !== (e >= 7) || busy !== (e >= 3 && e <= 6)) begin
        miscompares++;
        $display("FAIL press edge=%0d key_out=%b busy=%b expected %b %b",
                 e, key_out, busy, (e >= 7), (e >= 3 && e <= 6));
      end
      if (key_out && !prev) rises++;
      prev = key_out;
    end
    vectors++;
    if (rises != 1) begin
      miscompares++;
      $display("FAIL press_rise_count got=%0d expected 1", rises);
    end
  endtask

  // 3. Bounce 1,0,1,0 (2 cycles each) then 1 held: rise 7 edges after final 0->1.
  task automatic test_bounce();
    logic [7:0] pat;
    idle(1'b0, 12);
    vectors++;
    if (key_out !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_pre key_out=%b expected 0", key_out);
    end
    pat = 8'b0011_0011;
    for (int i = 0; i < 8; i++) begin
      key_in = pat[i];
      tick();
      vectors++;
      if (key_out !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce_phase step=%0d key_out=%b expected 0", i, key_out);
      end
    end
    key_in = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (key_out !== (e >= 7)) begin
        miscompares++;
        $display("FAIL bounce_final edge=%0d key_out=%b expected %b", e, key_out, (e >= 7));
      end
    end
  endtask

  // 4. Release with a 1-cycle high glitch seen by the FSM while cnt=2.
  task automatic test_glitch_release();
    logic exp_busy;
    for (int e = 1; e <= 12; e++) begin
      key_in = (e == 4);
      tick();
      exp_busy = (e >= 3 && e <= 5) || (e >= 7 && e <= 10);
      vectors++;
      if (key_out !== (e < 11) || busy !== exp_busy) begin
        miscompares++;
        $display("FAIL glitch_release edge=%0d key_out=%b busy=%b expected %b %b",
                 e, key_out, busy, (e < 11), exp_busy);
      end
    end
  endtask

  // Input returns low exactly on the expiry cycle: abort wins, no transition.
  task automatic test_abort_at_expiry();
    for (int e = 1; e <= 10; e++) begin
      key_in = (e <= 4);
      tick();
      vectors++;
      if (key_out !== 1'b0 || busy !== (e >= 3 && e <= 6)) begin
        miscompares++;
        $display("FAIL abort_expiry edge=%0d key_out=%b busy=%b expected 0 %b",
                 e, key_out, busy, (e >= 3 && e <= 6));
      end
    end
  endtask

  // 5. Reset asserted in S_RISE with cnt=3 discards the partial count.
  task automatic test_reset_mid_qual();
    key_in = 1'b1;
    for (int e = 1; e <= 6; e++) tick();
    vectors++;
    if (busy !== 1'b1 || dut.cnt !== 3'd3 || key_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midqual_setup busy=%b cnt=%0d key_out=%b expected 1 3 0", busy, dut.cnt, key_out);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (key_out !== 1'b0 || busy !== 1'b0 || dut.cnt !== 3'd0) begin
        miscompares++;
        $display("FAIL midqual_reset cyc=%0d key_out=%b busy=%b cnt=%0d expected 0 0 0",
                 i, key_out, busy, dut.cnt);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (key_out !== (e >= 7)) begin
        miscompares++;
        $display("FAIL midqual_requal edge=%0d key_out=%b expected %b", e, key_out, (e >= 7));
      end
    end
  endtask

  // 6. Downstream edge detector sees one posedge and one negedge pulse.
  task automatic test_edge_chain();
    logic a_d;
    int npos, nneg, pos_at, neg_at;
    idle(1'b0, 12);
    a_d = key_out;
    npos = 0; nneg = 0; pos_at = -1; neg_at = -1;
    for (int t = 1; t <= 24; t++) begin
      key_in = (t <= 12);
      tick();
      if (key_out && !a_d) begin npos++; pos_at = t; end
      if (!key_out && a_d) begin nneg++; neg_at = t; end
      a_d = key_out;
    end
    vectors++;
    if (npos != 1 || pos_at != 7) begin
      miscompares++;
      $display("FAIL chain_posedge count=%0d at=%0d expected 1 at 7", npos, pos_at);
    end
    vectors++;
    if (nneg != 1 || neg_at != 19) begin
      miscompares++;
      $display("FAIL chain_negedge count=%0d at=%0d expected 1 at 19", nneg, neg_at);
    end
  endtask

  initial begin
    rst = 1'b1;
    key_in = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch_release();
    test_abort_at_expiry();
    test_reset_mid_qual();
    test_edge_chain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
